// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: control-vector bit layout, MIPS opcode/funct codes,
// ALU encodings and the instruction-class decoder used by the decode stage.
package decode_stage_pkg;

    localparam int SIG_W_DEFAULT = 8;

    localparam int SIG_ALUSRC   = 7;
    localparam int SIG_MEMTOREG = 6;
    localparam int SIG_REGWRITE = 5;
    localparam int SIG_MEMREAD  = 4;
    localparam int SIG_MEMWRITE = 3;
    localparam int SIG_BRANCH   = 2;
    localparam int SIG_EQ       = 1;
    localparam int SIG_GOTO     = 0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [5:0] {
        ALU_NOP = 6'd0,
        ALU_ADD = 6'd1,
        ALU_SUB = 6'd2,
        ALU_AND = 6'd3,
        ALU_OR  = 6'd4,
        ALU_SLT = 6'd5
    } alu_op_e;

    typedef struct packed {
        logic [SIG_W_DEFAULT-1:0] sig;
        alu_op_e                  alu_op;
        logic                     zero_ext;
        logic                     rtype;
    } decode_t;

    // Unknown opcodes and R-type functs decode to a harmless no-op.
    function automatic decode_t decode_signals(input logic [5:0] op, input logic [5:0] funct);
        decode_t d;
        d = '0;
        case (op)
            OP_RTYPE: begin
                d.rtype = 1'b1;
                d.sig[SIG_REGWRITE] = 1'b1;
                case (funct)
                    FN_ADD:  d.alu_op = ALU_ADD;
                    FN_SUB:  d.alu_op = ALU_SUB;
                    FN_AND:  d.alu_op = ALU_AND;
                    FN_OR:   d.alu_op = ALU_OR;
                    FN_SLT:  d.alu_op = ALU_SLT;
                    default: d.sig = '0;
                endcase
            end
            OP_ADDI: begin
                d.sig[SIG_ALUSRC]   = 1'b1;
                d.sig[SIG_REGWRITE] = 1'b1;
                d.alu_op = ALU_ADD;
            end
            OP_ANDI, OP_ORI: begin
                d.sig[SIG_ALUSRC]   = 1'b1;
                d.sig[SIG_REGWRITE] = 1'b1;
                d.zero_ext = 1'b1;
                d.alu_op = (op == OP_ANDI) ? ALU_AND : ALU_OR;
            end
            OP_LW: begin
                d.sig[SIG_ALUSRC]   = 1'b1;
                d.sig[SIG_MEMTOREG] = 1'b1;
                d.sig[SIG_REGWRITE] = 1'b1;
                d.sig[SIG_MEMREAD]  = 1'b1;
                d.alu_op = ALU_ADD;
            end
            OP_SW: begin
                d.sig[SIG_ALUSRC]   = 1'b1;
                d.sig[SIG_MEMWRITE] = 1'b1;
                d.alu_op = ALU_ADD;
            end
            OP_BEQ, OP_BNE: begin
                d.sig[SIG_BRANCH] = 1'b1;
                d.sig[SIG_EQ]     = (op == OP_BEQ);
                d.alu_op = ALU_SUB;
            end
            OP_J:    d.sig[SIG_GOTO] = 1'b1;
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side handshake, writeback port, flush and the ID/EX output register bundle.
interface decode_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int SIG_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instruction;
    logic [DATA_W-1:0] in_address;
    logic              wb_write;
    logic [REG_AW-1:0] wb_address;
    logic [DATA_W-1:0] wb_data;
    logic              flush;
    logic              out_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_valA;
    logic [DATA_W-1:0] out_valB;
    logic [DATA_W-1:0] out_immediate;
    logic [REG_AW-1:0] out_rs;
    logic [REG_AW-1:0] out_rt;
    logic [REG_AW-1:0] out_destination;
    logic [DATA_W-1:0] out_goto_address;
    logic [5:0]        out_opcode;
    logic [SIG_W-1:0]  out_signals;

    modport master (
        output in_valid, in_instruction, in_address, wb_write, wb_address, wb_data,
               flush, out_ready,
        input  in_ready, out_valid, out_valA, out_valB, out_immediate, out_rs, out_rt,
               out_destination, out_goto_address, out_opcode, out_signals
    );

    modport slave (
        input  in_valid, in_instruction, in_address, wb_write, wb_address, wb_data,
               flush, out_ready,
        output in_ready, out_valid, out_valA, out_valB, out_immediate, out_rs, out_rt,
               out_destination, out_goto_address, out_opcode, out_signals
    );
endinterface

// File: rtl/decode_stage_regfile_bypass.sv
// Two-read one-write register file with hardwired zero register and same-cycle
// writeback bypass on both read ports.
module regfile_bypass #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [REG_AW-1:0]      wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic [1:0][REG_AW-1:0] rd_addr,
    output logic [1:0][DATA_W-1:0] rd_data
);
    localparam int N_REGS = 2 ** REG_AW;

    logic [DATA_W-1:0] regs_reg [N_REGS];
    logic              wr_live;

    // Writes to register 0 are discarded so it stays at its reset value of zero.
    assign wr_live = wr_en && (wr_addr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wr_live) begin
            regs_reg[wr_addr] <= wr_data;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read
            assign rd_data[gi] = (rd_addr[gi] == '0)                  ? '0      :
                                 (wr_live && wr_addr == rd_addr[gi])  ? wr_data :
                                                                        regs_reg[rd_addr[gi]];
        end
    endgenerate

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decodes fetched instructions, reads operands with writeback
// bypass, stalls on load-use hazards and holds the result in the ID/EX register.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int SIG_W  = SIG_W_DEFAULT
) (
    input logic clk,
    input logic rst,
    decode_stage_if.slave bus
);
    logic [31:0]            instr;
    logic [REG_AW-1:0]      in_rs, in_rt, in_rd, in_dest;
    decode_t                dec;
    logic [1:0][DATA_W-1:0] rd_data;
    logic [DATA_W-1:0]      pc_plus4, imm_ext, goto_addr;
    logic                   unused_pc_low;
    logic                   hazard, free, take;
    logic                   wb_hit_rs, wb_hit_rt;

    logic                   valid_reg;
    logic [DATA_W-1:0]      val_a_reg, val_b_reg, imm_reg, goto_reg;
    logic [REG_AW-1:0]      rs_reg, rt_reg, dest_reg;
    logic [5:0]             opcode_reg;
    logic [SIG_W-1:0]       sig_reg;

    assign instr   = bus.in_instruction;
    assign in_rs   = REG_AW'(instr[25:21]);
    assign in_rt   = REG_AW'(instr[20:16]);
    assign in_rd   = REG_AW'(instr[15:11]);
    assign dec     = decode_signals(instr[31:26], instr[5:0]);
    assign in_dest = dec.rtype ? in_rd : in_rt;
    assign imm_ext = dec.zero_ext ? DATA_W'(instr[15:0])
                                  : {{(DATA_W-16){instr[15]}}, instr[15:0]};

    // Jump target keeps the top nibble of pc+4; its low bits are replaced by the index.
    assign pc_plus4      = bus.in_address + DATA_W'(4);
    assign goto_addr     = {pc_plus4[DATA_W-1:28], instr[25:0], 2'b00};
    assign unused_pc_low = ^pc_plus4[27:0];

    regfile_bypass #(
        .DATA_W(DATA_W),
        .REG_AW(REG_AW)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (bus.wb_write),
        .wr_addr(bus.wb_address),
        .wr_data(bus.wb_data),
        .rd_addr({in_rt, in_rs}),
        .rd_data(rd_data)
    );

    // A held load whose destination feeds the incoming instruction must leave first.
    assign hazard = valid_reg && sig_reg[SIG_MEMREAD] && (dest_reg != '0) &&
                    ((dest_reg == in_rs) || (dest_reg == in_rt));
    assign free         = !valid_reg || bus.out_ready;
    assign take         = bus.in_valid && !hazard;
    assign bus.in_ready = bus.flush || (free && !hazard);

    assign wb_hit_rs = bus.wb_write && (bus.wb_address != '0) && (bus.wb_address == rs_reg);
    assign wb_hit_rt = bus.wb_write && (bus.wb_address != '0) && (bus.wb_address == rt_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg  <= 1'b0;
            val_a_reg  <= '0;
            val_b_reg  <= '0;
            imm_reg    <= '0;
            goto_reg   <= '0;
            rs_reg     <= '0;
            rt_reg     <= '0;
            dest_reg   <= '0;
            opcode_reg <= '0;
            sig_reg    <= '0;
        end else if (bus.flush) begin
            valid_reg <= 1'b0;
        end else if (free) begin
            valid_reg <= take;
            if (take) begin
                val_a_reg  <= rd_data[0];
                val_b_reg  <= rd_data[1];
                imm_reg    <= imm_ext;
                goto_reg   <= goto_addr;
                rs_reg     <= in_rs;
                rt_reg     <= in_rt;
                dest_reg   <= in_dest;
                opcode_reg <= dec.alu_op;
                sig_reg    <= SIG_W'(dec.sig);
            end
        end else begin
            // Stalled: keep operands current with writebacks that land while we wait.
            if (wb_hit_rs) val_a_reg <= bus.wb_data;
            if (wb_hit_rt) val_b_reg <= bus.wb_data;
        end
    end

    assign bus.out_valid        = valid_reg;
    assign bus.out_valA         = val_a_reg;
    assign bus.out_valB         = val_b_reg;
    assign bus.out_immediate    = imm_reg;
    assign bus.out_goto_address = goto_reg;
    assign bus.out_rs           = rs_reg;
    assign bus.out_rt           = rt_reg;
    assign bus.out_destination  = dest_reg;
    assign bus.out_opcode       = opcode_reg;
    assign bus.out_signals      = sig_reg;

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised, registered successor to the combinational decode stage. It accepts fetched instructions over a valid/ready handshake and reads operands from an internal register file with same-cycle writeback bypass. It also detects load-use hazards, inserting a bubble, and honours a flush from the branch unit. Its outputs form the ID/EX pipeline register feeding the execute stage.

## Interface
- DATA_W, 32, datapath and register width
- REG_AW, 5, register address width; register count = 2**REG_AW, register 0 hardwired to zero
- SIG_W, 8, control-signal vector width (bit layout from shared defs)
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts this cycle (combinational)
- in_instruction  in  32  instruction word
- in_address  in  DATA_W  instruction address
- wb_write  in  1  writeback enable
- wb_address  in  REG_AW  writeback register
- wb_data  in  DATA_W  writeback data
- flush  in  1  discard held and incoming instruction
- out_ready  in  1  execute accepts the held instruction
- out_valid  out  1  held instruction is valid
- out_valA, out_valB  out  DATA_W  operands for rs [25:21] and rt [20:16]
- out_immediate  out  DATA_W  extended [15:0], sign or zero per decode
- out_rs, out_rt  out  REG_AW  source register numbers (for downstream forwarding)
- out_destination  out  REG_AW  [15:11] for R-type, [20:16] otherwise
- out_goto_address  out  DATA_W  jump target
- out_opcode  out  6  ALU opcode
- out_signals  out  SIG_W  control vector: [7] ALUSrc, [6] MemToReg, [5] reg_write, [4] MemRead, [3] MemWrite, [2] branch, [1] eq, [0] goto_flg

## Operation
- Decode of opcode, signals, immediate, destination and jump target follows the existing decode rules. Results are captured into the output register on acceptance.
- Register file: writes occur on a rising edge when wb_write is high and wb_address is nonzero. Reads are combinational.
- Bypass: a read of register R while wb_write is high and wb_address=R≠0 returns wb_data in the same cycle.
- Hazard rule: hazard=out_valid & out_signals[4] & out_destination≠0 & (out_destination==rs of in_instruction | out_destination==rt of in_instruction).
- free = !out_valid | out_ready.
- in_ready = flush | (free & !hazard).
- Update rules, in priority order:
  - reset: out_valid=0 and every output 0.
  - flush: next out_valid=0. The incoming instruction is consumed and dropped. out_ready is ignored.
  - free: out_valid<=in_valid & !hazard. Payload is captured only when in_valid & !hazard. Under a hazard, the load leaves and a bubble (out_valid=0) follows.
  - otherwise (held, stalled): payload is held. Operand refresh applies: if wb_write and wb_address≠0 equals out_rs (or out_rt), out_valA (or out_valB) <= wb_data.
- Register 0 always reads 0, even when wb_address=0 with wb_write high.
- Register file contents are reset to 0.

## Timing
- Latency 1 cycle: an instruction accepted at edge N is visible with out_valid=1 after edge N.
- Throughput 1 per cycle when out_ready is held high and no hazards occur.
- A load-use pair costs exactly one bubble cycle.
- Flush takes effect at the next edge. in_ready is high during the flush cycle.
- Simultaneous flush and hazard: flush wins and no bubble is counted.
- Reset asserted mid-transfer: out_valid drops immediately (asynchronous). Nothing is accepted while reset is high.
- in_ready depends combinationally on out_ready, out_valid and in_instruction. It has no dependence on in_valid.

## Structure
- Shared include mips_defs.vh holds:
  - signal bit indices (SIG_ALUSRC … SIG_GOTO)
  - opcode/funct localparams
  - ALU opcode encodings
  - the default SIG_W
- One sub-module, regfile_bypass (2R1W, parametrised by DATA_W/REG_AW, zero register, write bypass).
- Decode logic reuses the existing decode_signals, sign_ext and jump_target.
- Hazard, handshake and the pipeline register live in decode_stage.

## Test plan
- Reset with out_ready=1, then present add $3,$1,$2 (0x00221820) with $1=5, $2=7 preloaded via wb:
  - one cycle later: out_valid=1, valA=5, valB=7, destination=3, signals[5]=1.
- Bypass: wb_write of $1=0x1234 in the same cycle the instruction is presented → out_valA=0x1234. wb_address=0 with data 0xFFFF → $0 still reads 0.
- Load-use: lw $4,0($1) followed by add $5,$4,$2:
  - in_ready=0 for one cycle, then a one-cycle out_valid=0 bubble after the lw.
  - the add issues next, with no data loss.
- Backpressure: out_ready=0 for 3 cycles → outputs stable and in_ready=0. A wb write to the held rs during the stall updates out_valA.
- Flush: assert flush while a valid instruction is held and a new one is presented:
  - next cycle out_valid=0.
  - the presented instruction never appears.
  - flush together with a hazard yields no extra bubble.
- Asynchronous reset mid-stream: out_valid falls without a clock edge. After release, registers read 0.
